// File: rtl/stack_driver.sv
// stack_driver: host-side sequencer for a small LIFO stack block.
// Takes one request at a time, drives the stack's COMMAND/INDEX pins and the
// shared IO_DATA bus, captures read data and returns one response per request.
// Occupancy is mirrored locally so bad requests never reach the stack.
//
// Handshakes (both ports): a transfer happens on a rising CLK edge where
// VALID and READY are both high. The producer holds VALID and its payload
// stable until that edge; READY may be asserted independently of VALID.
module stack_driver #(
  parameter int DEPTH = 5,
  parameter int W     = 4,
  parameter int IW    = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [1:0]    REQ_OP,
  input  logic [W-1:0]  REQ_DATA,
  input  logic [IW-1:0] REQ_INDEX,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [W-1:0]  RSP_DATA,
  output logic          RSP_ERR,
  output logic [2:0]    COUNT,
  inout  wire  [W-1:0]  IO_DATA,
  output logic [1:0]    COMMAND,
  output logic [IW-1:0] INDEX,
  output logic [1:0]    dbg_state,
  output logic          dbg_io_oe
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_GET  = 2'b11;
  localparam logic [2:0] FULL    = 3'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  data_q, data_d;
  logic [IW-1:0] index_q, index_d;
  logic [2:0]    count_q, count_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          req_err;
  logic          io_oe;

  // Reject requests the stack cannot legally execute given current occupancy.
  always_comb begin
    req_err = 1'b0;
    unique case (REQ_OP)
      OP_PUSH: req_err = (count_q == FULL);
      OP_POP:  req_err = (count_q == 3'd0);
      OP_GET:  req_err = (count_q == 3'd0) || (3'(REQ_INDEX) >= count_q);
      default: req_err = 1'b0;
    endcase
  end

  // Next-state, request latching, occupancy mirror and response capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    index_d    = index_q;
    count_d    = count_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          op_d       = REQ_OP;
          data_d     = REQ_DATA;
          index_d    = REQ_INDEX;
          rsp_data_d = '0;
          rsp_err_d  = req_err;
          state_d    = (req_err || REQ_OP == OP_NOP) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The stack executes on the edge that ends this cycle.
        unique case (op_q)
          OP_PUSH: begin
            count_d = count_q + 3'd1;
            state_d = S_RESP;
          end
          OP_POP: begin
            count_d = count_q - 3'd1;
            state_d = S_CAPTURE;
          end
          OP_GET:  state_d = S_CAPTURE;
          default: state_d = S_RESP;
        endcase
      end
      S_CAPTURE: begin
        // Stack owns the bus for the whole cycle; sample at its end.
        rsp_data_d = IO_DATA;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; RESET aborts any request in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      data_q     <= '0;
      index_q    <= '0;
      count_q    <= 3'd0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      index_q    <= index_d;
      count_q    <= count_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Pin outputs are pure decodes of registered state, so they are glitch-free
  // relative to the stack's sampling edge.
  always_comb begin
    REQ_READY = (state_q == S_IDLE);
    RSP_VALID = (state_q == S_RESP);
    COMMAND   = (state_q == S_ISSUE) ? op_q : OP_NOP;
    INDEX     = (state_q == S_ISSUE && op_q == OP_GET) ? index_q : '0;
    io_oe     = (state_q == S_ISSUE && op_q == OP_PUSH);
  end

  assign IO_DATA   = io_oe ? data_q : 'z;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign COUNT     = count_q;
  assign dbg_state = state_q;
  assign dbg_io_oe = io_oe;

endmodule

// File: doc/stack_driver.md
# stack_driver

Host-side sequencer for the 5-entry, 4-bit stack block. Accepts push/pop/get requests on a valid/ready port and drives the stack's `COMMAND`/`INDEX` pins and shared tri-state `IO_DATA` bus. It captures read data from the bus and returns one response per request on a valid/ready port. It mirrors stack occupancy and rejects overflow, underflow and out-of-range reads before they reach the stack.

## Interface
- `DEPTH`, 5: stack entries.
- `W`, 4: data width.
- `IW`, 3: index width.
- `CLK` in 1: single clock; all state changes on rising edge.
- `RESET` in 1: synchronous, active-high. Shared with the stack.
- `REQ_VALID` in 1: request present.
- `REQ_READY` out 1: request accepted when `REQ_VALID & REQ_READY` at an edge.
- `REQ_OP` in 2: 00 nop, 01 push, 10 pop, 11 get.
- `REQ_DATA` in W: push data.
- `REQ_INDEX` in IW: get index; 0 is top of stack (most recent push).
- `RSP_VALID` out 1: response present; held until accepted.
- `RSP_READY` in 1: response consumed when `RSP_VALID & RSP_READY` at an edge.
- `RSP_DATA` out W: pop/get data; 0 for push, nop and errors.
- `RSP_ERR` out 1: request rejected; no stack command issued.
- `COUNT` out 3: mirrored occupancy, 0..DEPTH.
- `IO_DATA` inout W: stack data bus. Driven only during ISSUE of a push; `Z` otherwise.
- `COMMAND` out 2: stack command, same encoding as `REQ_OP`.
- `INDEX` out IW: stack index; equals latched index during ISSUE, 0 otherwise.

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: `REQ_READY`=1, `COMMAND`=00, bus `Z`.
  - On accept, latch op, data and index.
  - Push with `COUNT`==DEPTH: error, go to RESP.
  - Pop with `COUNT`==0: error, go to RESP.
  - Get with `COUNT`==0 or index ≥ `COUNT`: error, go to RESP.
  - Nop: go to RESP, err=0, data 0.
  - Otherwise: go to ISSUE.
- ISSUE (1 cycle): `COMMAND`=latched op, `INDEX`=latched index (get) else 0. Push drives `IO_DATA`=latched data. The stack acts on the edge ending ISSUE.
  - At that edge, push increments `COUNT` and goes to RESP.
  - Pop decrements `COUNT` and goes to CAPTURE.
  - Get leaves `COUNT` unchanged and goes to CAPTURE.
- CAPTURE (1 cycle): `COMMAND`=00, bus `Z`. `RSP_DATA` is loaded from `IO_DATA` on the edge ending CAPTURE; the stack drives the bus throughout this cycle. Then go to RESP.
- RESP: `RSP_VALID`=1, `RSP_DATA`/`RSP_ERR` stable, `REQ_READY`=0, `COMMAND`=00. On `RSP_READY`, go to IDLE.
- Errors never change `COUNT` and never produce a non-00 `COMMAND`.
- `COUNT` saturates by construction: never exceeds DEPTH, never underflows.
- Driver and stack never drive `IO_DATA` simultaneously. The driver drives only in ISSUE-push; the stack drives only after a pop/get edge.

## Timing
- Reset values: state IDLE, `REQ_READY`=1, `RSP_VALID`=0, `RSP_DATA`=0, `RSP_ERR`=0, `COUNT`=0, `COMMAND`=00, `INDEX`=0, `IO_DATA`=`Z`.
- `RESET` in any state, including mid-ISSUE or mid-CAPTURE, aborts the request; no response is produced. `RESET` has priority over all transitions.
- Latency, request-accept edge E0 to `RSP_VALID` high:
  - Error or nop: RESP after E0 (1 cycle).
  - Push: RESP after E1 (2 cycles).
  - Pop/get: RESP after E2 (3 cycles).
- Throughput: at most one request in flight. The next accept is possible on the edge after response acceptance, since IDLE is entered then.
- `RSP_READY` high while `RSP_VALID`=0 has no effect. `REQ_VALID` is ignored while `REQ_READY`=0.
- `COUNT` updates on the edge ending ISSUE and is visible in the following cycle.

## Test plan
- Reset, then push 3,7,9,E -> four responses err=0, data 0. `COUNT` steps 1,2,3,4. `IO_DATA` equals pushed value only in each ISSUE cycle.
- After that, get index 0 -> E; get index 3 -> 3; get index 4 -> err=1 with `COMMAND` staying 00; then pop -> E with `COUNT`=3.
- Fill to 5 entries, push again -> err=1, `COUNT` stays 5, no 01 on `COMMAND`. Pop 5 times -> LIFO order, then pop -> err=1 at `COUNT`=0.
- Hold `RSP_READY`=0 for 4 cycles after a pop -> `RSP_VALID`/`RSP_DATA` stable, `REQ_READY`=0. Release -> IDLE next cycle. Back-to-back request accepted one cycle later.
- Assert `RESET` during CAPTURE of a get -> next cycle: IDLE, `COUNT`=0, bus `Z`, no `RSP_VALID`. A following pop -> err=1.
- Nop request -> `RSP_VALID` one cycle after accept, err=0, data 0, `COMMAND` never leaves 00.
